// File: rtl/sys_bridge.sv
// CPU-to-device bridge: decodes a 16-byte window per device plus one bridge register window.
// Optional build macro BRIDGE_TIMEOUT_EN bounds the time spent waiting for a device ack.
module sys_bridge #(
  parameter int unsigned        NDEV    = 3,
  parameter int unsigned        ADDR_W  = 14,
  parameter logic [ADDR_W-1:0]  BASE    = 14'h3F00,
  parameter int unsigned        TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [31:0]          cpu_wd,
  output logic [31:0]          cpu_rd,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic [NDEV-1:0]      dev_sel,
  output logic                 dev_we,
  output logic [3:0]           dev_addr,
  output logic [31:0]          dev_wd,
  input  logic [NDEV*32-1:0]   dev_rd,
  input  logic [NDEV-1:0]      dev_ack,
  input  logic [NDEV-1:0]      dev_irq,
  output logic [5:0]           hwint
);

  localparam int unsigned BLK_W = ADDR_W - 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

  stateT             stateQ, stateD;
  logic [31:0]       rdD;
  logic              readyD, errD, weD;
  logic [NDEV-1:0]   selD;
  logic [3:0]        addrD;
  logic [31:0]       wdD;
  logic [NDEV-1:0]   imaskQ, imaskD, ipendQ, ipendD, ipendClr;
  logic [5:0]        hwintD;
  logic [31:0]       devRd;
  logic              ackHit;

  // Window decode on 16-byte block numbers; BASE is assumed 16-byte aligned.
  logic [BLK_W:0]    blkOff;
  logic [BLK_W-1:0]  blkIdx;
  logic              hitDev, hitReg;

  assign blkOff = {1'b0, cpu_addr[ADDR_W-1:4]} - {1'b0, BASE[ADDR_W-1:4]};
  assign blkIdx = blkOff[BLK_W-1:0];
  assign hitDev = !blkOff[BLK_W] && (blkIdx < BLK_W'(NDEV));
  assign hitReg = !blkOff[BLK_W] && (blkIdx == BLK_W'(NDEV));

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] toCntQ, toCntD;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^32'(TIMEOUT);
`endif

  // Read-data mux over the selected device; only acks from the selected device count.
  always_comb begin
    devRd = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (dev_sel[i]) devRd = devRd | dev_rd[32*i +: 32];
    end
    ackHit = |(dev_ack & dev_sel);
  end

  always_comb begin
    stateD   = stateQ;
    rdD      = cpu_rd;
    readyD   = 1'b0;
    errD     = 1'b0;
    selD     = dev_sel;
    weD      = dev_we;
    addrD    = dev_addr;
    wdD      = dev_wd;
    imaskD   = imaskQ;
    ipendClr = '0;
`ifdef BRIDGE_TIMEOUT_EN
    toCntD   = toCntQ;
`endif
    unique case (stateQ)
      IDLE: begin
        if (cpu_req) begin
          if (hitDev) begin
            stateD = ACCESS;
            selD   = NDEV'(1) << blkIdx;
            weD    = cpu_we;
            addrD  = cpu_addr[3:0];
            wdD    = cpu_wd;
`ifdef BRIDGE_TIMEOUT_EN
            toCntD = '0;
`endif
          end else if (hitReg) begin
            stateD = DONE;
            readyD = 1'b1;
            rdD    = '0;
            if (cpu_addr[3:0] == 4'd0) begin
              if (cpu_we) imaskD = cpu_wd[NDEV-1:0];
              else        rdD    = 32'(imaskQ);
            end else if (cpu_addr[3:0] == 4'd4) begin
              if (cpu_we) ipendClr = cpu_wd[NDEV-1:0];
              else        rdD      = 32'(ipendQ);
            end
          end else begin
            stateD = DONE;
            readyD = 1'b1;
            errD   = 1'b1;
            rdD    = '0;
          end
        end
      end
      ACCESS: begin
        if (ackHit) begin
          stateD = DONE;
          readyD = 1'b1;
          rdD    = dev_we ? 32'd0 : devRd;
          selD   = '0;
        end
`ifdef BRIDGE_TIMEOUT_EN
        else if (toCntQ == CNT_W'(TIMEOUT - 1)) begin
          stateD = DONE;
          readyD = 1'b1;
          errD   = 1'b1;
          rdD    = '0;
          selD   = '0;
        end else begin
          toCntD = toCntQ + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        stateD = IDLE;
        selD   = '0;
      end
      default: stateD = IDLE;
    endcase
    // A pending set in the same cycle as a W1C clear wins.
    ipendD = (ipendQ & ~ipendClr) | dev_irq;
    hwintD = 6'(ipendD & imaskD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      cpu_rd    <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      dev_sel   <= '0;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_wd    <= '0;
      imaskQ    <= '0;
      ipendQ    <= '0;
      hwint     <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      toCntQ    <= '0;
`endif
    end else begin
      stateQ    <= stateD;
      cpu_rd    <= rdD;
      cpu_ready <= readyD;
      cpu_err   <= errD;
      dev_sel   <= selD;
      dev_we    <= weD;
      dev_addr  <= addrD;
      dev_wd    <= wdD;
      imaskQ    <= imaskD;
      ipendQ    <= ipendD;
      hwint     <= hwintD;
`ifdef BRIDGE_TIMEOUT_EN
      toCntQ    <= toCntD;
`endif
    end
  end

endmodule

// File: tb/tb_sys_bridge.sv
// Randomized self-checking bench for sys_bridge against an address-map/transaction-level model.
module tb_sys_bridge;
  localparam int unsigned NDEV    = 3;
  localparam int unsigned ADDR_W  = 14;
  localparam logic [13:0] BASE    = 14'h3F00;
  localparam int unsigned TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0]   cpu_addr = '0;
  logic [31:0]         cpu_wd = '0;
  logic [31:0]         cpu_rd;
  logic                cpu_ready, cpu_err;
  logic [NDEV-1:0]     dev_sel;
  logic                dev_we;
  logic [3:0]          dev_addr;
  logic [31:0]         dev_wd;
  logic [NDEV*32-1:0]  dev_rd = '0;
  logic [NDEV-1:0]     dev_ack = '0, dev_irq = '0;
  logic [5:0]          hwint;

  always #5 clk = ~clk;

  sys_bridge #(.NDEV(NDEV), .ADDR_W(ADDR_W), .BASE(BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wd(dev_wd),
    .dev_rd(dev_rd), .dev_ack(dev_ack), .dev_irq(dev_irq), .hwint(hwint)
  );

  int nCmp = 0, nBad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Interrupt register model: IPEND accumulates irq levels, W1C loses to a same-cycle set.
  logic [NDEV-1:0] mImask = '0, mIpend = '0, mClr = '0, mMaskVal = '0;
  logic            mMaskWe = 1'b0;
  bit              irqRand = 1'b0, pinRd0 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mIpend = '0;
      mImask = '0;
    end else begin
      mIpend = (mIpend & ~mClr) | dev_irq;
      if (mMaskWe) mImask = mMaskVal;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    check("hwint", 32'(hwint), 32'(mIpend & mImask));
    if (!cpu_ready) check("errWithoutReady", 32'(cpu_err), 32'd0);
    for (int i = 0; i < NDEV; i++) dev_rd[32*i +: 32] = $urandom;
    if (pinRd0) dev_rd[31:0] = 32'hCAFE_F00D;
    dev_ack = NDEV'($urandom);
    if (irqRand) dev_irq = NDEV'($urandom);
  endtask

  // One complete CPU transaction; expected behaviour derived from the address map.
  task automatic doAccess(input logic we, input logic [13:0] addr, input logic [31:0] wd,
                          input int lat, output logic [31:0] gotRd);
    int a, kind, idx, off;
    logic [31:0] expRd;
    logic [NDEV-1:0] sel;
    a = int'(addr);
    idx = 0;
    if (a >= int'(BASE) && a < int'(BASE) + 16*NDEV) begin
      kind = 0; idx = (a - int'(BASE)) / 16;
    end else if (a >= int'(BASE) && a < int'(BASE) + 16*(NDEV+1)) kind = 1;
    else kind = 2;
    off = a % 16;
    sel = NDEV'(1) << idx;
    expRd = 32'd0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wd = wd;
    if (kind == 1 && off == 0) begin
      if (we) begin mMaskWe = 1'b1; mMaskVal = wd[NDEV-1:0]; end
      else expRd = 32'(mImask);
    end else if (kind == 1 && off == 4) begin
      if (we) mClr = wd[NDEV-1:0];
      else expRd = 32'(mIpend);
    end
    tick();
    cpu_req = 1'b0; mClr = '0; mMaskWe = 1'b0;
    cpu_we = 1'($urandom); cpu_addr = ADDR_W'($urandom); cpu_wd = $urandom;
    if (kind == 0) begin
      check("selOnEntry", 32'(dev_sel), 32'(sel));
      check("devWe", 32'(dev_we), 32'(we));
      check("devAddr", 32'(dev_addr), 32'(off));
      check("devWd", dev_wd, wd);
      check("noEarlyReady", 32'(cpu_ready), 32'd0);
      for (int c = 0; c < lat; c++) begin
        dev_ack = dev_ack & ~sel;
        tick();
        check("selHeld", 32'(dev_sel), 32'(sel));
        check("wdHeld", dev_wd, wd);
        check("waitNoReady", 32'(cpu_ready), 32'd0);
      end
      dev_ack = dev_ack | sel;
      expRd = we ? 32'd0 : dev_rd[32*idx +: 32];
      tick();
    end
    check("ready", 32'(cpu_ready), 32'd1);
    check("err", 32'(cpu_err), (kind == 2) ? 32'd1 : 32'd0);
    check("rd", cpu_rd, expRd);
    check("selDone", 32'(dev_sel), 32'd0);
    gotRd = cpu_rd;
    tick();
    check("readyOnePulse", 32'(cpu_ready), 32'd0);
  endtask

  task automatic startDev2();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h3F2C;
    tick();
    cpu_req = 1'b0;
  endtask

  logic [31:0] r;
  logic [13:0] ra;
  bit seenReady;

  initial begin
    #2;
    check("rstReady", 32'(cpu_ready), 32'd0);
    check("rstSel", 32'(dev_sel), 32'd0);
    check("rstRd", cpu_rd, 32'd0);
    check("rstHwint", 32'(hwint), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    doAccess(1'b1, 14'h3F14, 32'h1234_5678, 3, r);
    pinRd0 = 1'b1;
    doAccess(1'b0, 14'h3F08, 32'h0, 0, r);
    check("rdCafe", r, 32'hCAFE_F00D);
    pinRd0 = 1'b0;
    doAccess(1'b0, 14'h0100, 32'h0, 0, r);
    check("unmappedRd", r, 32'd0);

    dev_irq = '0;
    doAccess(1'b1, 14'h3F30, 32'h5, 0, r);
    dev_irq = 3'b111; tick(); dev_irq = '0; tick();
    check("hwint101", 32'(hwint), 32'h05);
    dev_irq = 3'b001;
    doAccess(1'b1, 14'h3F34, 32'h1, 0, r);
    doAccess(1'b0, 14'h3F34, 32'h0, 0, r);
    check("ipend0Sticks", 32'(r[0]), 32'd1);
    dev_irq = '0;
    doAccess(1'b1, 14'h3F34, 32'h4, 0, r);
    doAccess(1'b0, 14'h3F34, 32'h0, 0, r);
    check("ipend2Cleared", 32'(r[2]), 32'd0);
    doAccess(1'b0, 14'h3F38, 32'h0, 0, r);

    irqRand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      int cls;
      cls = $urandom_range(0, 3);
      if (cls <= 1) ra = BASE + 14'(16 * $urandom_range(0, NDEV-1) + $urandom_range(0, 15));
      else if (cls == 2) ra = BASE + 14'(16 * NDEV + 4 * $urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 0) ra = 14'($urandom_range(0, int'(BASE) - 1));
      else ra = 14'($urandom_range(int'(BASE) + 16*(NDEV+1), 16383));
      doAccess(1'($urandom), ra, $urandom, $urandom_range(0, 5), r);
      repeat ($urandom_range(0, 2)) tick();
    end
    irqRand = 1'b0;
    dev_irq = '0;

    doAccess(1'b1, 14'h3F30, 32'h7, 0, r);
    dev_irq = 3'b111; tick(); dev_irq = '0; tick();
    check("hwintAll", 32'(hwint), 32'h07);

    startDev2();
    check("selDev2", 32'(dev_sel), 32'h4);
`ifdef BRIDGE_TIMEOUT_EN
    for (int c = 0; c < int'(TIMEOUT) - 1; c++) begin
      dev_ack = dev_ack & 3'b011;
      tick();
      check("toWait", 32'(cpu_ready), 32'd0);
    end
    dev_ack = dev_ack & 3'b011;
    tick();
    check("toReady", 32'(cpu_ready), 32'd1);
    check("toErr", 32'(cpu_err), 32'd1);
    check("toRd", cpu_rd, 32'd0);
    check("toSel", 32'(dev_sel), 32'd0);
    tick();
    startDev2();
`else
    seenReady = 1'b0;
    for (int c = 0; c < 100; c++) begin
      dev_ack = dev_ack & 3'b011;
      tick();
      if (cpu_ready) seenReady = 1'b1;
    end
    check("noTimeoutReady", 32'(seenReady), 32'd0);
    check("stillSel", 32'(dev_sel), 32'h4);
`endif
    dev_ack = '0;
    #2 rst_n = 1'b0;
    #1;
    check("abortSel", 32'(dev_sel), 32'd0);
    check("abortReady", 32'(cpu_ready), 32'd0);
    check("abortHwint", 32'(hwint), 32'd0);
    tick();
    check("rstHoldReady", 32'(cpu_ready), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("postRstReady", 32'(cpu_ready), 32'd0);
    doAccess(1'b0, 14'h3F30, 32'h0, 0, r);
    check("imaskCleared", r, 32'd0);
    doAccess(1'b0, 14'h3F34, 32'h0, 0, r);
    check("ipendCleared", r, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/sys_bridge.md
SYS_BRIDGE -- requirements
Module: sys_bridge

Interface
REQ-001 Parameter NDEV, default 3: number of device channels, legal range 1..6.
REQ-002 Parameter ADDR_W, default 14: CPU byte-address width.
REQ-003 Parameter BASE, default 14'h3F00: start of the device region; device i owns [BASE+16*i, BASE+16*i+15]; the bridge's own registers own [BASE+16*NDEV, +15].
REQ-004 Parameter TIMEOUT, default 16: ACCESS-state cycle limit, used only when BRIDGE_TIMEOUT_EN is defined.
REQ-005 One clock; reset is asynchronous and active-low: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-006 cpu_req in 1: access request, sampled only in IDLE.
REQ-007 cpu_we in 1: 1 = write, 0 = read.
REQ-008 cpu_addr in ADDR_W: byte address.
REQ-009 cpu_wd in 32: write data.
REQ-010 cpu_rd out 32: registered read data, valid while cpu_ready is 1.
REQ-011 cpu_ready out 1: one-cycle completion pulse.
REQ-012 cpu_err out 1: error flag, asserted only together with cpu_ready.
REQ-013 dev_sel out NDEV: one-hot device select.
REQ-014 dev_we out 1: write enable, qualified by dev_sel.
REQ-015 dev_addr out 4: offset within the 16-byte window.
REQ-016 dev_wd out 32: latched write data.
REQ-017 dev_rd in NDEV*32: device i read data in bits [32*i+31 : 32*i].
REQ-018 dev_ack in NDEV: per-device completion.
REQ-019 dev_irq in NDEV: level interrupt requests.
REQ-020 hwint out 6: {zeros, pend & mask}, zero-extended to 6 bits.

Function
REQ-021 FSM states: IDLE, ACCESS, DONE.
REQ-022 IDLE, cpu_req=1, address hits device i: latch we, addr[3:0] and wd, then go to ACCESS.
REQ-023 IDLE, cpu_req=1, address hits a bridge register: perform the register access, then go to DONE.
REQ-024 IDLE, cpu_req=1, unmapped address: go to DONE with err=1 and rd=0; no device is selected.
REQ-025 ACCESS: dev_sel[i]=1 and dev_we/dev_addr/dev_wd are held stable; on dev_ack[i]=1, capture the dev_rd slice i into cpu_rd (0 on writes), then go to DONE.
REQ-026 dev_ack from non-selected devices is ignored; dev_ack in IDLE or DONE is ignored.
REQ-027 DONE: cpu_ready=1 for exactly one cycle and dev_sel=0, then go to IDLE; a new request is sampled no earlier than the cycle after DONE.
REQ-028 Latency, register or unmapped access: request sampled at edge k -> cpu_ready high in the cycle after edge k.
REQ-029 Latency, device access: earliest ack at edge k+1 -> cpu_ready high in the cycle after k+1.
REQ-030 Bridge register offset 0, IMASK: read/write, NDEV bits; offset 4, IPEND: read, write-1-to-clear; other offsets read 0 and ignore writes, no error.
REQ-031 IPEND[i] is set in every cycle dev_irq[i]=1; a set in the same cycle as a W1C clear wins.
REQ-032 Unused upper bits of register reads are 0; hwint bits NDEV..5 are always 0.
REQ-033 Reset asserted mid-transaction: abort immediately; no cpu_ready pulse.

Reset
REQ-034 rst_n=0 asynchronously forces: state IDLE, cpu_rd=0, cpu_ready=0, cpu_err=0, dev_sel=0, dev_we=0, dev_addr=0, dev_wd=0, IMASK=0, IPEND=0, hwint=0, timeout counter=0.
REQ-035 Release of rst_n takes effect at the next rising edge of clk.

Configuration
REQ-036 Macro BRIDGE_TIMEOUT_EN defined: a counter clears on entering ACCESS; if TIMEOUT cycles pass in ACCESS without ack, go to DONE with err=1 and rd=0, and dev_sel drops.
REQ-037 Macro BRIDGE_TIMEOUT_EN undefined: ACCESS waits indefinitely; cpu_err arises only from unmapped addresses.

Verification
REQ-038 Write 32'h1234_5678 to 14'h3F14 (device 1); ack after 3 cycles -> dev_sel=3'b010, dev_addr=4, dev_wd held; one ready pulse; err=0.
REQ-039 Read 14'h3F08 (device 0) with dev_rd slice 0 = 32'hCAFE_F00D and ack on the first ACCESS cycle -> cpu_rd=32'hCAFE_F00D; ready in the 2nd cycle after the request edge.
REQ-040 Read 14'h0100 (unmapped) -> ready after 1 cycle; err=1; rd=0; dev_sel stays 0.
REQ-041 Write IMASK=3'b101 at 14'h3F30; pulse dev_irq=3'b111 -> hwint=6'b000101; W1C IPEND=3'b001 while dev_irq[0]=1 -> IPEND[0] stays 1.
REQ-042 With BRIDGE_TIMEOUT_EN, TIMEOUT=16, device never acks -> ready and err after 16 ACCESS cycles; without the macro, no ready after 100 cycles.
REQ-043 Assert rst_n=0 during ACCESS -> dev_sel=0 and state IDLE immediately; no ready pulse; IMASK=0 and IPEND=0.
